// File: rtl/dec_pkg.sv
// Shared widths and decode/one-hot helpers for the 3-to-8 decoder.
package dec_pkg;

  localparam int DEC_IN_W  = 3;
  localparam int DEC_OUT_W = 8;

  function automatic logic [DEC_OUT_W-1:0] onehot_dec(input logic [DEC_IN_W-1:0] sel, input logic en);
    logic [DEC_OUT_W-1:0] res;
    res = 8'h00;
    // X/Z on sel while disabled must never reach the output.
    if (en) begin
      case (sel)
        3'd0:    res = 8'h01;
        3'd1:    res = 8'h02;
        3'd2:    res = 8'h04;
        3'd3:    res = 8'h08;
        3'd4:    res = 8'h10;
        3'd5:    res = 8'h20;
        3'd6:    res = 8'h40;
        3'd7:    res = 8'h80;
        default: res = 8'h00;
      endcase
    end else begin
      res = 8'h00;
    end
    return res;
  endfunction

  function automatic logic is_onehot(input logic [DEC_OUT_W-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < DEC_OUT_W; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return (cnt == 4'd1);
  endfunction

endpackage

// File: rtl/dec_onehot_chk.sv
// Simulation assertion on the decoder output invariant; built only with DECODER_ONEHOT_CHK_EN.
`ifdef DECODER_ONEHOT_CHK_EN
module dec_onehot_chk
  import dec_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  input logic [DEC_OUT_W-1:0] out,
  input logic                 valid
);

  a_out_inv: assert property (@(posedge clk) disable iff (!rst_n)
    (valid ? is_onehot(out) : (out == 8'h00)))
    else $error("decoder output invariant violated: out=%h valid=%b", out, valid);

endmodule
`endif

// File: rtl/dec_onehot_core.sv
// Purely combinational 3-to-8 one-hot decode.
module dec_onehot_core
  import dec_pkg::*;
(
  input  logic [DEC_IN_W-1:0]  in,
  input  logic                 en,
  output logic [DEC_OUT_W-1:0] dec
);

  // Decode select into one-hot lines, gated by enable.
  always_comb begin
    dec = onehot_dec(in, en);
  end

endmodule

// File: rtl/decoder_3_to_8.sv
// Registered 3-to-8 decoder with enable; optional sticky invariant flag `err`
// is compiled in when DECODER_ONEHOT_CHK_EN is defined.
module decoder_3_to_8
  import dec_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DEC_IN_W-1:0]  in,
  input  logic                 en,
  output logic [DEC_OUT_W-1:0] out,
  output logic                 valid
`ifdef DECODER_ONEHOT_CHK_EN
  ,
  output logic                 err
`endif
);

  logic [DEC_OUT_W-1:0] dec_s;

  dec_onehot_core u_core (
    .in  (in),
    .en  (en),
    .dec (dec_s)
  );

  if (OUT_REG != 0) begin : g_reg
    logic [DEC_OUT_W-1:0] out_r;
    logic                 valid_r;

    // Output register: glitch-free selects, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_r   <= 8'h00;
        valid_r <= 1'b0;
      end else begin
        out_r   <= dec_s;
        valid_r <= en;
      end
    end

    assign out   = out_r;
    assign valid = valid_r;
  end else begin : g_comb
    assign out   = dec_s;
    assign valid = en;
  end

`ifdef DECODER_ONEHOT_CHK_EN
  logic inv_bad_s;
  logic err_r;

  // Invariant: one-hot while valid, all-zero otherwise.
  always_comb begin
    if (valid) begin
      inv_bad_s = !is_onehot(out);
    end else begin
      inv_bad_s = (out != 8'h00);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | inv_bad_s;
    end
  end

  assign err = err_r;

  dec_onehot_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (out),
    .valid (valid)
  );
`endif

endmodule

// File: tb/tb_decoder_3_to_8.sv
// Self-checking bench for decoder_3_to_8: directed cases plus random stimulus vs. a shift-based model.
module tb_decoder_3_to_8;

  logic       clk;
  logic       rst_n;
  logic [2:0] in;
  logic       en;
  logic [7:0] out;
  logic       valid;
`ifdef DECODER_ONEHOT_CHK_EN
  logic       err;
`endif

  int tests_run;
  int tests_failed;

  decoder_3_to_8 #(.OUT_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .en    (en),
    .out   (out),
    .valid (valid)
`ifdef DECODER_ONEHOT_CHK_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic e, input logic [2:0] s);
    if (e) return 8'(9'd1 << s);
    return 8'h00;
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one vector, let it load, then check output and valid.
  task automatic step(input string tag, input logic e, input logic [2:0] s);
    @(negedge clk);
    en = e;
    in = s;
    @(posedge clk);
    #1;
    check_eq(tag, out, model(e, s));
    check_eq({tag, "_valid"}, {7'd0, valid}, {7'd0, e});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b1;
    en    = 1'b0;
    in    = 3'd0;

    // Load a nonzero value, then reset asynchronously between edges.
    step("pre_reset", 1'b1, 3'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_out", out, 8'h00);
    check_eq("async_reset_valid", {7'd0, valid}, 8'h00);
    @(posedge clk);
    #1;
    check_eq("reset_held_out", out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("release_first_edge", out, 8'h08);

    // Full sweep of {en,in}, with a mid-operation reset pulse.
    for (int v = 0; v < 16; v++) begin
      logic [3:0] vec;
      vec = 4'(v);
      step($sformatf("sweep_%0d", v), vec[3], vec[2:0]);
`ifdef DECODER_ONEHOT_CHK_EN
      check_eq("sweep_err", {7'd0, err}, 8'h00);
`endif
      if (v == 10) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_reset_out", out, 8'h00);
        #1;
        rst_n = 1'b1;
      end
    end

    // Enable gating and back-to-back decodes.
    step("gate_on", 1'b1, 3'd5);
    step("gate_off", 1'b0, 3'd5);
    step("b2b_7", 1'b1, 3'd7);
    step("b2b_0", 1'b1, 3'd0);

    // X on select while disabled must decode to zero.
    @(negedge clk);
    en = 1'b0;
    in = 3'bxxx;
    @(posedge clk);
    #1;
    check_eq("x_sel_disabled", out, 8'h00);

    // Random stimulus against the model.
    for (int i = 0; i < 200; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

`ifdef DECODER_ONEHOT_CHK_EN
    $assertoff;
    @(negedge clk);
    en = 1'b1;
    in = 3'd2;
    force dut.out = 8'h03;
    @(posedge clk);
    #1;
    @(negedge clk);
    release dut.out;
    check_eq("err_set", {7'd0, err}, 8'h01);
    step("err_after_release", 1'b1, 3'd4);
    check_eq("err_sticky", {7'd0, err}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("err_cleared", {7'd0, err}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    $asserton;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
